fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch and program-counter sequencer for the 8-bit processor core. Drives the instruction byte into the control decoder and consumes the decoder's `branchf`, `branchb` and `done` outputs to choose the next PC. It owns a small branch-offset lookup table, a start/halt handshake with the testbench or host, and an optional executed-cycle counter.

## Interface
Parameters:
- `PC_W`, 10, program counter and instruction-memory address width
- `OFF_W`, 8, branch offset width; unsigned, zero-extended to `PC_W`
- `CNT_W`, 16, cycle counter width

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge
- `reset_i`  in  1  synchronous, active-high reset
- `start_i`  in  1  begin execution at `start_addr_i`
- `start_addr_i`  in  PC_W  initial PC loaded on accepted start
- `imem_addr_o`  out  PC_W  instruction memory address; always equals `pc_o`
- `imem_data_i`  in  8  instruction byte, combinational read of `imem_addr_o`
- `instruction_o`  out  8  instruction byte to the decoder
- `branchf_i`  in  1  decoder forward-branch-taken
- `branchb_i`  in  1  decoder backward-branch-taken
- `done_i`  in  1  decoder halt-decoded
- `lut_we_i`  in  1  branch LUT write enable
- `lut_addr_i`  in  3  branch LUT write index
- `lut_data_i`  in  OFF_W  branch LUT write data
- `pc_o`  out  PC_W  current program counter
- `done_o`  out  1  program halted, level
- `cycles_o`  out  CNT_W  RUN-state cycle count

## Operation
- FSM states: IDLE, RUN, HALTED. Reset → IDLE.
- Reset values: `pc_o`=0, `done_o`=0, `cycles_o`=0, all 8 LUT entries=0; `instruction_o`=8'h88 (halt opcode).
- IDLE: `instruction_o`=8'h88. `start_i`=1 → `pc`←`start_addr_i`, `cycles`←0, go RUN.
- RUN: `instruction_o`=`imem_data_i`. Each edge, in priority order:
  - `done_i`=1 → go HALTED, `pc` holds, `done_o`←1. Branch inputs are ignored.
  - `branchf_i`=1 → `pc`←`pc`+LUT[`instruction_o[2:0]`].
  - `branchb_i`=1 → `pc`←`pc`−LUT[`instruction_o[2:0]`].
  - Otherwise `pc`←`pc`+1.
- If `branchf_i` and `branchb_i` are both 1 (illegal from decoder), forward wins.
- PC arithmetic is modulo 2^PC_W. Forward wraps past max to low addresses, backward wraps below 0 to high addresses.
- `start_i` in RUN is ignored.
- HALTED: `instruction_o`=8'h88, `pc` and `cycles` frozen, `done_o`=1. `start_i`=1 → `done_o`←0, `pc`←`start_addr_i`, `cycles`←0, go RUN.
- LUT writes are accepted only in IDLE or HALTED. Writes in RUN are dropped. A write plus a start on the same edge: the write lands, and the new value is visible on the first RUN cycle.
- Reset in any state (including mid-RUN) overrides everything: back to IDLE with the reset values above; LUT is cleared.

## Timing
- Instruction fetch has zero latency: `instruction_o` reflects `imem_data_i` for the current `pc_o` in the same cycle.
- Next-PC decision is registered. A branch observed in cycle N gives the target on `pc_o` in cycle N+1. There is no delay slot.
- Halt instruction at cycle N: `done_o` rises in N+1, and `pc_o` still points at the halt instruction.
- `cycles_o` increments on every edge taken in RUN, including the edge that enters HALTED. It saturates at 2^CNT_W−1.
- Start to first fetch: `start_i` high at edge E → `pc_o`=`start_addr_i` and RUN from E.

## Configuration
- `FETCH_CYCLE_COUNT_EN` defined: the cycle counter is built and behaves as described.
- Not defined: no counter register is built, and `cycles_o` is tied to 0.

## Test plan
- Reset, then start with `start_addr_i`=0x010 on a program of four add bytes followed by halt (0x88): `pc_o` goes 0x10→0x14; `done_o`=1 one cycle after 0x14 is fetched; `cycles_o`=5; `pc_o` holds at 0x14.
- LUT[3]=5 written in IDLE; at pc=0x020, force `branchf_i`=1 with `instruction_o[2:0]`=3 → next `pc_o`=0x025. Repeat with `branchb_i`=1 → next `pc_o`=0x01B.
- Wrap: pc=0x3FE, branchf with offset 4 → 0x002. pc=0x001, branchb with offset 3 → 0x3FE.
- Both `branchf_i` and `branchb_i`=1 with offset 2 at pc=0x100 → 0x102. `done_i` together with `branchf_i` → HALTED, pc unchanged.
- HALTED, then restart with `start_addr_i`=0x000 → `done_o` falls on the same edge, `cycles_o`=0, fetch resumes at 0. `lut_we_i` during RUN → LUT entry unchanged, verified by a later branch.
- Assert `reset_i` mid-RUN at pc=0x033 → next cycle IDLE, `pc_o`=0, `instruction_o`=0x88, LUT entries read back as 0 via branch offsets. Without `FETCH_CYCLE_COUNT_EN`, `cycles_o` stays 0 throughout.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-unit bus: start/halt handshake, instruction memory, decoder feedback and branch LUT writes.
// The master side is the fetch unit; the slave side is the host, memory and decoder.
interface fetch_if #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8,
    parameter int CNT_W = 16
);
    logic             start_i;
    logic [PC_W-1:0]  start_addr_i;
    logic [PC_W-1:0]  imem_addr_o;
    logic [7:0]       imem_data_i;
    logic [7:0]       instruction_o;
    logic             branchf_i;
    logic             branchb_i;
    logic             done_i;
    logic             lut_we_i;
    logic [2:0]       lut_addr_i;
    logic [OFF_W-1:0] lut_data_i;
    logic [PC_W-1:0]  pc_o;
    logic             done_o;
    logic [CNT_W-1:0] cycles_o;

    modport master (
        input  start_i, start_addr_i, imem_data_i, branchf_i, branchb_i, done_i,
               lut_we_i, lut_addr_i, lut_data_i,
        output imem_addr_o, instruction_o, pc_o, done_o, cycles_o
    );

    modport slave (
        output start_i, start_addr_i, imem_data_i, branchf_i, branchb_i, done_i,
               lut_we_i, lut_addr_i, lut_data_i,
        input  imem_addr_o, instruction_o, pc_o, done_o, cycles_o
    );
endinterface

// File: rtl/fetch_unit.sv
// PC sequencer with zero-latency fetch and registered next-PC; no backpressure, inputs sampled every edge.
// Optional RUN-cycle counter built only when FETCH_CYCLE_COUNT_EN is defined.
module fetch_unit #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8,
    parameter int CNT_W = 16
) (
    input  logic      clk_i,
    input  logic      reset_i,
    fetch_if.master   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

    localparam logic [7:0] HALT_OP = 8'h88;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             done_q, done_d;
    logic             lut_wr_ok;
    logic [OFF_W-1:0] lut_q [8];
    logic [7:0]       instr;
    logic [PC_W-1:0]  offset;

    // Offsets are unsigned; the cast zero-extends to PC width.
    assign offset = PC_W'(lut_q[instr[2:0]]);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        done_d    = done_q;
        lut_wr_ok = 1'b0;
        instr     = HALT_OP;
        case (state_q)
            S_RUN: begin
                instr = bus.imem_data_i;
                if (bus.done_i) begin
                    state_d = S_HALTED;
                    done_d  = 1'b1;
                end else if (bus.branchf_i) begin
                    pc_d = pc_q + offset;
                end else if (bus.branchb_i) begin
                    pc_d = pc_q - offset;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: begin
                lut_wr_ok = 1'b1;
                if (bus.start_i) begin
                    state_d = S_RUN;
                    pc_d    = bus.start_addr_i;
                    done_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < 8; i++) lut_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            if (lut_wr_ok && bus.lut_we_i) lut_q[bus.lut_addr_i] <= bus.lut_data_i;
        end
    end

`ifdef FETCH_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cycles_q;

    // Saturating count of edges taken in RUN, cleared by an accepted start.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cycles_q <= '0;
        end else if (state_q != S_RUN && bus.start_i) begin
            cycles_q <= '0;
        end else if (state_q == S_RUN && cycles_q != '1) begin
            cycles_q <= cycles_q + CNT_W'(1);
        end
    end

    assign bus.cycles_o = cycles_q;
`else
    assign bus.cycles_o = '0;
`endif

    assign bus.imem_addr_o   = pc_q;
    assign bus.pc_o          = pc_q;
    assign bus.done_o        = done_q;
    assign bus.instruction_o = instr;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized decoder/host traffic.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_if bus ();

    fetch_unit dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    logic [7:0] mem [0:1023];
    assign bus.imem_data_i = mem[bus.imem_addr_o];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: running/halted flags, PC as an integer mod 1024, LUT as ints.
    bit m_run, m_halt, m_done;
    int m_pc, m_cyc;
    int m_lut [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cycles();
`ifdef FETCH_CYCLE_COUNT_EN
        return m_cyc;
`else
        return 0;
`endif
    endfunction

    task automatic model_step(input bit r, st, input int sa, input bit bf, bb, dn,
                              input bit we, input int wa, wd);
        int off;
        if (r) begin
            m_run = 0; m_halt = 0; m_done = 0; m_pc = 0; m_cyc = 0;
            for (int i = 0; i < 8; i++) m_lut[i] = 0;
        end else if (!m_run) begin
            if (we) m_lut[wa] = wd;
            if (st) begin
                m_run = 1; m_halt = 0; m_done = 0; m_pc = sa; m_cyc = 0;
            end
        end else begin
            off = m_lut[mem[m_pc] % 8];
            if (m_cyc < 65535) m_cyc = m_cyc + 1;
            if (dn) begin
                m_run = 0; m_halt = 1; m_done = 1;
            end else if (bf) m_pc = (m_pc + off) % 1024;
            else if (bb) m_pc = (m_pc - off + 1024) % 1024;
            else m_pc = (m_pc + 1) % 1024;
        end
    endtask

    // Drive at the falling edge, step the model at the rising edge, compare at the next falling edge.
    task automatic cyc(input bit r, st, input int sa, input bit bf, bb, dn,
                       input bit we, input int wa, wd);
        rst              = r;
        bus.start_i      = st;
        bus.start_addr_i = 10'(sa);
        bus.branchf_i    = bf;
        bus.branchb_i    = bb;
        bus.done_i       = dn;
        bus.lut_we_i     = we;
        bus.lut_addr_i   = 3'(wa);
        bus.lut_data_i   = 8'(wd);
        @(posedge clk);
        model_step(r, st, sa, bf, bb, dn, we, wa, wd);
        @(negedge clk);
        chk("pc", bus.pc_o, m_pc);
        chk("imem_addr", bus.imem_addr_o, m_pc);
        chk("done", bus.done_o, m_done);
        chk("cycles", bus.cycles_o, exp_cycles());
        chk("instr", bus.instruction_o, m_run ? mem[m_pc] : 8'h88);
    endtask

    task automatic step(input bit st, input int sa, input bit bf, bb, dn);
        cyc(0, st, sa, bf, bb, dn, 0, 0, 0);
    endtask

    task automatic lutw(input int a, d);
        cyc(0, 0, 0, 0, 0, 0, 1, a, d);
    endtask

    task automatic rst_cyc();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit r, st, bf, bb, dn, we;
        int k;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h01;
        rst = 1'b1;
        bus.start_i = 0; bus.start_addr_i = '0; bus.branchf_i = 0; bus.branchb_i = 0;
        bus.done_i = 0; bus.lut_we_i = 0; bus.lut_addr_i = '0; bus.lut_data_i = '0;

        // Reset state
        rst_cyc();
        rst_cyc();
        chk("rst_pc", bus.pc_o, 0);
        chk("rst_instr", bus.instruction_o, 8'h88);
        chk("rst_done", bus.done_o, 0);

        // Four adds then halt from 0x010
        for (int a = 'h10; a < 'h14; a++) mem[a] = 8'h01;
        mem['h14] = 8'h88;
        step(1, 'h10, 0, 0, 0);
        chk("t1_start_pc", bus.pc_o, 'h10);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, m_run && mem[m_pc] == 8'h88);
        chk("t1_pc", bus.pc_o, 'h14);
        chk("t1_done", bus.done_o, 1);
`ifdef FETCH_CYCLE_COUNT_EN
        chk("t1_cycles", bus.cycles_o, 5);
`else
        chk("t1_cycles", bus.cycles_o, 0);
`endif
        step(0, 0, 0, 0, 0);
        chk("t1_hold", bus.pc_o, 'h14);

        // Forward / backward branch via LUT[3]=5
        rst_cyc();
        lutw(3, 5);
        mem['h20] = 8'h03;
        step(1, 'h20, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("bf_pc", bus.pc_o, 'h25);
        step(0, 0, 0, 0, 1);
        step(1, 'h20, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("bb_pc", bus.pc_o, 'h1B);
        step(0, 0, 0, 0, 1);

        // Wrap-around both directions
        lutw(4, 4);
        mem['h3FE] = 8'h04;
        step(1, 'h3FE, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("wrap_fwd", bus.pc_o, 'h002);
        step(0, 0, 0, 0, 1);
        lutw(5, 3);
        mem['h001] = 8'h05;
        step(1, 'h001, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("wrap_bwd", bus.pc_o, 'h3FE);
        step(0, 0, 0, 0, 1);

        // Both branches: forward wins; done beats branch
        lutw(2, 2);
        mem['h100] = 8'h02;
        step(1, 'h100, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        chk("both_pc", bus.pc_o, 'h102);
        step(0, 0, 1, 0, 1);
        chk("done_br_pc", bus.pc_o, 'h102);
        chk("done_br_done", bus.done_o, 1);

        // Restart from HALTED, then a LUT write during RUN is dropped
        step(1, 'h000, 0, 0, 0);
        chk("restart_done", bus.done_o, 0);
        chk("restart_pc", bus.pc_o, 0);
        chk("restart_cycles", bus.cycles_o, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 2, 7);
        step(0, 0, 0, 0, 1);
        step(1, 'h100, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("lut_run_drop", bus.pc_o, 'h102);

        // Reset mid-RUN clears everything including the LUT
        step(0, 0, 0, 0, 1);
        step(1, 'h033, 0, 0, 0);
        chk("pre_rst_pc", bus.pc_o, 'h033);
        rst_cyc();
        chk("midrst_pc", bus.pc_o, 0);
        chk("midrst_instr", bus.instruction_o, 8'h88);
        step(1, 'h100, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("lut_cleared", bus.pc_o, 'h100);

        // Randomized traffic against the model
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            st = ($urandom_range(0, 3) == 0);
            k  = $urandom_range(0, 15);
            dn = (k == 0);
            bf = (k >= 1 && k <= 4);
            bb = (k >= 3 && k <= 6);
            we = ($urandom_range(0, 2) == 0);
            cyc(r, st, $urandom_range(0, 1023), bf, bb, dn, we,
                $urandom_range(0, 7), $urandom_range(0, 255));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
